// File: rtl/mips_pkg.sv
// Shared MIPS encodings and loader FSM state type.
// LOADER_VERIFY_EN adds the read-back states RD and CMP.
package mips_pkg;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;
    localparam logic [1:0] FMT_X = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WR,
`ifdef LOADER_VERIFY_EN
        S_RD,
        S_CMP,
`endif
        S_DONE
    } ld_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational MIPS field packer: fmt + fields -> 32-bit word.
// Illegal fmt yields a NOP and raises the illegal flag.
module instr_encoder
    import mips_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        unique case (fmt)
            FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   word = {opcode, rs, rt, imm};
            FMT_J:   word = {opcode, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Packs field tuples into IMEM at sequential addresses, holding the CPU until loaded.
// Define LOADER_VERIFY_EN to read back and compare each written word.
module imem_loader
    import mips_pkg::*;
#(
    parameter int AW        = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    fmt,
    input  logic [5:0]    opcode,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    input  logic          last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    input  logic [31:0]   imem_rdata,
    output logic          cpu_hold,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err
);

    localparam logic [AW-1:0] BASE_A  = AW'(BASE_ADDR);
    localparam logic [AW-1:0] LAST_A  = AW'(BASE_ADDR + DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   DEPTH_M = (AW+1)'(DEPTH - 1);

    ld_state_t   state, state_nx;
    logic [31:0] enc_word;
    logic        enc_ill;
    logic        ill_q;
    logic        last_q;
    logic        start_ok;
    logic        accept;
    logic        fin;
    logic        full;
    logic        ovf;

    instr_encoder u_enc (
        .fmt     (fmt),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm     (imm),
        .target  (target),
        .word    (enc_word),
        .illegal (enc_ill)
    );

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign accept   = in_valid && (state == S_LOAD);

    // fin marks the cycle a word is complete; count already holds its increment under verify
`ifdef LOADER_VERIFY_EN
    assign fin  = (state == S_CMP);
    assign full = (count == DEPTH_C);
`else
    assign fin  = (state == S_WR);
    assign full = (count == DEPTH_M);

    logic unused_rdata;
    assign unused_rdata = ^imem_rdata;
`endif

    assign ovf = fin && !last_q && full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            imem_addr  <= BASE_A;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
            ill_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                imem_addr <= BASE_A;
                count     <= '0;
                err       <= 1'b0;
            end
            if (accept) begin
                imem_wdata <= enc_word;
                ill_q      <= enc_ill;
                last_q     <= last;
            end
            if (state == S_WR) begin
                if (count != DEPTH_C) count <= count + 1'b1;
                if (ill_q) err <= 1'b1;
            end
            if (fin && imem_addr != LAST_A) imem_addr <= imem_addr + 1'b1;
            if (ovf) err <= 1'b1;
`ifdef LOADER_VERIFY_EN
            if (state == S_CMP && imem_rdata != imem_wdata) err <= 1'b1;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        imem_we  = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_WR;
            end
            S_WR: begin
                imem_we = 1'b1;
`ifdef LOADER_VERIFY_EN
                state_nx = S_RD;
            end
            S_RD:  state_nx = S_CMP;
            S_CMP: begin
`endif
                state_nx = (last_q || full) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_LOAD;
            end
            default: state_nx = S_IDLE;
        endcase
        cpu_hold = !done;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table vectors plus multi-cycle sequences.
// Exercises the read-back path when LOADER_VERIFY_EN is defined.
module tb_imem_loader;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = '0;
    logic [5:0]  opcode = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        last = 1'b0;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata = '0;
    logic        cpu_hold, done, err;
    logic [6:0]  count;
    logic [31:0] ref_word;
    logic        ref_ill;

    int nvec = 0;
    int nbad = 0;

    logic [31:0] mem [64];
    logic        corrupt = 1'b0;
    logic [5:0]  wa[$];
    logic [31:0] wd[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm        (imm),
        .target     (target),
        .last       (last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .count      (count),
        .err        (err)
    );

    instr_encoder u_ref (
        .fmt     (fmt),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm     (imm),
        .target  (target),
        .word    (ref_word),
        .illegal (ref_ill)
    );

    // IMEM model: sync read, optional bit-0 fault on word 1
    always @(posedge clk) begin
        if (imem_we)
            mem[imem_addr] <= imem_wdata ^ {31'd0, corrupt && imem_addr == 6'd1};
        imem_rdata <= mem[imem_addr];
    end

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    typedef struct {
        logic [1:0]  f;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clear_log;
        wa.delete();
        wd.delete();
        exp_q.delete();
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive(input logic [1:0] f, input logic [5:0] op,
                         input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [4:0] s,
                         input logic [5:0] fn, input logic [15:0] im,
                         input logic [25:0] tg, input logic l);
        fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = s;
        funct = fn; imm = im; target = tg; last = l;
    endtask

    task automatic scramble;
        drive(2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom),
              26'($urandom), 1'($urandom));
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op,
                        input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] s,
                        input logic [5:0] fn, input logic [15:0] im,
                        input logic [25:0] tg, input logic l);
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("ready", 32'(in_ready), 32'd1);
        drive(f, op, a, b, c, s, fn, im, tg, l);
        in_valid = 1'b1;
        #1;
        exp_q.push_back(ref_word);
        tick();
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("done", 32'(done), 32'd1);
    endtask

    task automatic check_log(input string tag, input int n);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size() && i < exp_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(wa[i]), 32'(i));
            chk({tag, "_data"}, wd[i], exp_q[i]);
        end
    endtask

    initial begin
        vt[0] = '{FMT_R, OP_RTYPE, 5'd8, 5'd9, 5'd10, 5'd0, F_ADD,
                  16'hFFFF, 26'h3FFFFFF, 32'h01095020, 1'b0};
        vt[1] = '{FMT_I, OP_LW, 5'd16, 5'd8, 5'd31, 5'd31, 6'h3F,
                  16'h0004, 26'h0, 32'h8E080004, 1'b0};
        vt[2] = '{FMT_J, OP_J, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F,
                  16'hFFFF, 26'h0100000, 32'h08100000, 1'b0};
        vt[3] = '{FMT_X, OP_LW, 5'd1, 5'd2, 5'd3, 5'd4, F_ADD,
                  16'h1234, 26'h1234567, 32'h00000000, 1'b1};
        vt[4] = '{FMT_I, OP_SW, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0,
                  16'hFFFC, 26'h0, 32'hAFBFFFFC, 1'b0};
        vt[5] = '{FMT_I, OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0,
                  16'h8000, 26'h0, 32'h10228000, 1'b0};
        vt[6] = '{FMT_R, OP_RTYPE, 5'd0, 5'd9, 5'd10, 5'd31, F_SLL,
                  16'h0, 26'h0, 32'h000957C0, 1'b0};
        vt[7] = '{FMT_R, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F,
                  16'h0, 26'h0, 32'hFFFFFFFF, 1'b0};

        tick();
        tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Single-word sessions from the table
        for (int v = 0; v < 8; v++) begin
            clear_log();
            do_start();
            chk("load_hold", 32'(cpu_hold), 32'd1);
            chk("load_done", 32'(done), 32'd0);
            send(vt[v].f, vt[v].op, vt[v].rs, vt[v].rt, vt[v].rd, vt[v].sh,
                 vt[v].fn, vt[v].imm, vt[v].tgt, 1'b1);
            wait_done();
            chk("v_nwr", 32'(wa.size()), 32'd1);
            chk("v_addr", wa.size() > 0 ? 32'(wa[0]) : 32'hDEAD, 32'd0);
            chk("v_word", wd.size() > 0 ? wd[0] : 32'hDEADBEEF, vt[v].word);
            chk("v_count", 32'(count), 32'd1);
            chk("v_err", 32'(err), 32'(vt[v].err));
            chk("v_hold", 32'(cpu_hold), 32'd0);
            chk("v_ready", 32'(in_ready), 32'd0);
        end

        // Two-word I/J stream
        clear_log();
        do_start();
        send(FMT_I, OP_LW, 5'd16, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
        send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000, 1'b1);
        wait_done();
        check_log("ij", 2);
        chk("ij_w0", wd.size() > 0 ? wd[0] : 32'hDEADBEEF, 32'h8E080004);
        chk("ij_w1", wd.size() > 1 ? wd[1] : 32'hDEADBEEF, 32'h08100000);
        chk("ij_count", 32'(count), 32'd2);
        chk("ij_err", 32'(err), 32'd0);

        // Back-pressure: in_valid held high across five tuples
        clear_log();
        do_start();
        begin
            int k = 0;
            int cyc = 0;
            drive(FMT_I, OP_LW, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd100, 26'd0, 1'b0);
            in_valid = 1'b1;
            while (k < 5 && cyc < 100) begin
                if (imem_we) chk("bp_rdy_wr", 32'(in_ready), 32'd0);
                if (in_ready) begin
                    #1;
                    exp_q.push_back(ref_word);
                    tick();
                    k++;
                    drive(FMT_I, OP_LW, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0,
                          16'(100 + k), 26'd0, k == 4);
                end else begin
                    tick();
                end
                cyc++;
            end
            chk("bp_accepts", 32'(k), 32'd5);
        end
        wait_done();
        repeat (5) tick();
        in_valid = 1'b0;
        check_log("bp", 5);
        chk("bp_count", 32'(count), 32'd5);

        // Restart from DONE writes from the base address again
        clear_log();
        do_start();
        send(FMT_R, OP_RTYPE, 5'd8, 5'd9, 5'd10, 5'd0, F_ADD, 16'd0, 26'd0, 1'b1);
        wait_done();
        check_log("rs", 1);

        // Reset in the middle of a load after three words
        clear_log();
        do_start();
        for (int i = 0; i < 3; i++)
            send(FMT_I, OP_SW, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
        repeat (4) tick();
        chk("mr_ready", 32'(in_ready), 32'd1);
        check_log("mr", 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_hold", 32'(cpu_hold), 32'd1);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_idle", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("mr_nwr", 32'(wa.size()), 32'd3);

        // Overflow: DEPTH tuples without last, then one more offered
        clear_log();
        do_start();
        for (int i = 0; i < 64; i++)
            send(FMT_I, OP_LW, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'(i * 3), 26'd0, 1'b0);
        wait_done();
        chk("ov_err", 32'(err), 32'd1);
        chk("ov_count", 32'(count), 32'd64);
        drive(FMT_I, OP_LW, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0, 1'b0);
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("ov_ready", 32'(in_ready), 32'd0);
        chk("ov_addr", 32'(imem_addr), 32'd63);
        check_log("ov", 64);

`ifdef LOADER_VERIFY_EN
        clear_log();
        corrupt = 1'b1;
        do_start();
        send(FMT_I, OP_LW, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h10, 26'd0, 1'b0);
        send(FMT_I, OP_LW, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h20, 26'd0, 1'b0);
        send(FMT_I, OP_LW, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h30, 26'd0, 1'b1);
        wait_done();
        corrupt = 1'b0;
        chk("vf_err", 32'(err), 32'd1);
        chk("vf_count", 32'(count), 32'd3);
        check_log("vf", 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
